sync_updown_counter: RTL and testbench
======================================

// Module: sync_updown_counter
// PURPOSE
//  Synchronous, fully clocked up/down counter. It complements our ripple-clocked down counter:
//  - one clock edge for every bit, so there is no ripple skew;
//  - direction select, parallel load, modulo limit, wrap/saturate choice;
//  - combinational terminal-count output for cascading stages.
//  Drives timers, display scanners and address generators in the lab designs.
// PARAMETERS
//  WIDTH     4    count register width in bits
//  MODULO    16   count range is 0..MODULO-1; 2 <= MODULO <= 2**WIDTH
//  SATURATE  0    0 = wrap at the limits, 1 = stop and hold at the limits
// PORTS
//  clk       in   1      single clock; all state updates on the rising edge
//  rst       in   1      synchronous, active-high reset
//  en        in   1      count enable; sampled each rising edge
//  up_dn     in   1      1 = count up, 0 = count down; sampled with en
//  load      in   1      parallel-load strobe
//  load_val  in   WIDTH  value to load
//  count     out  WIDTH  current count (registered)
//  tc        out  1      terminal count, combinational: en & (up_dn ? count==MODULO-1 : count==0)
//  wrap      out  1      registered 1-cycle pulse when count wrapped on the previous edge
//  sat       out  1      registered; high while held at a limit (SATURATE=1 only)
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge): count=0, wrap=0, sat=0, FSM=IDLE. rst overrides all inputs.
//    rst asserted mid-count clears the counter on that same edge.
//  - Priority each edge: rst > load > en. en=0 and load=0: count holds, wrap=0.
//  - Load: count<=load_val; if load_val>=MODULO, load MODULO-1 instead (clamp).
//    Load clears wrap and sat. FSM goes to IDLE, or to COUNT if en=1.
//  - Count up (en=1, up_dn=1):
//    - count<MODULO-1: count+1.
//    - At MODULO-1 with SATURATE=0: count<=0, wrap=1 for 1 cycle.
//    - At MODULO-1 with SATURATE=1: hold, sat<=1, FSM->SAT.
//  - Count down (en=1, up_dn=0):
//    - count>0: count-1.
//    - At 0 with SATURATE=0: count<=MODULO-1, wrap=1 for 1 cycle.
//    - At 0 with SATURATE=1: hold, sat<=1, FSM->SAT.
//  - Latency: count reflects en/up_dn one cycle after they are sampled. tc is same-cycle
//    (zero latency) so a cascaded stage can use tc as its en.
//  - Direction change while counting: takes effect on the next edge; no extra hold cycle.
//  - Arithmetic: WIDTH+1-bit internal sum; compare against MODULO-1 before truncating.
//    Out-of-range states are unreachable; if forced, the next enabled edge reloads 0.
//  - FSM states:
//    - IDLE: en=0.
//    - COUNT: en=1, not at a saturating limit.
//    - SAT: held at a limit. Leave SAT via load, rst, or en with the opposite direction;
//      sat drops on that same edge. en=0 in SAT keeps sat=1.
// STRUCTURE
//  - Shared header counter_defs.vh: FSM state encodings ST_IDLE=2'd0, ST_COUNT=2'd1, ST_SAT=2'd2;
//    DIR_UP=1'b1, DIR_DN=1'b0.
//  - One natural sub-module: counter_next_val (combinational).
//    - Inputs: count, up_dn, SATURATE.
//    - Outputs: next count, at_limit, wrap_evt.
//    - Top level keeps the registers, load clamp and FSM.
// TESTING
//  - Reset: drive rst=1 for 2 edges with en=1 -> count=0, wrap=0, sat=0, tc=0.
//  - Up wrap (MODULO=10, SATURATE=0): en=1, up_dn=1 for 10 edges from 0 -> count 1..9 then 0.
//    tc=1 while count=9; wrap=1 only in the cycle after 9->0.
//  - Down saturate (SATURATE=1): load 2, then en=1, up_dn=0 for 4 edges -> count 1, 0, 0, 0.
//    sat=1 from the first hold; then up_dn=1 -> count=1, sat=0.
//  - Load priority and clamp (MODULO=10): load=1 with load_val=13 and en=1 -> count=9.
//    Next edge with load=0, en=1, up wrap -> count=0, wrap=1.
//  - Mid-operation reset: count=7 counting up, rst=1 for one edge -> count=0.
//    Release rst -> count=1 on the following edge.
//  - Cascade: two 4-bit instances, the second's en tied to the first's tc, 256 up edges.
//    Combined value goes 0..255 then back to 0.

Source files
------------

// File: rtl/sync_updown_counter_pkg.sv
// Shared encodings for the synchronous up/down counter: FSM states and direction values.
package sync_updown_counter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_SAT   = 2'd2
   } state_t;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/sync_updown_counter_next_val.sv
// Combinational next-count logic: increment/decrement with modulo wrap or saturation.
module counter_next_val #(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned MODULO   = 16,
   parameter bit          SATURATE = 1'b0
) (
   input  logic [WIDTH-1:0] count,
   input  logic             up_dn,
   output logic [WIDTH-1:0] next_count,
   output logic             at_limit,
   output logic             wrap_evt
);
   import sync_updown_counter_pkg::*;

   localparam logic [WIDTH:0] LIM = (WIDTH+1)'(MODULO - 1);

   logic [WIDTH:0] ext;
   logic [WIDTH:0] sum_up;

   always_comb begin
      ext        = {1'b0, count};
      sum_up     = ext + (WIDTH+1)'(1);
      next_count = count - WIDTH'(1);
      at_limit   = 1'b0;
      wrap_evt   = 1'b0;
      // an out-of-range (forced) count recovers to 0 on the next enabled edge
      if (ext > LIM) begin
         next_count = '0;
      end else if (up_dn == DIR_UP) begin
         next_count = sum_up[WIDTH-1:0];
         if (sum_up > LIM) begin
            at_limit = 1'b1;
            if (SATURATE) begin
               next_count = count;
            end else begin
               next_count = '0;
               wrap_evt   = 1'b1;
            end
         end
      end else if (count == '0) begin
         at_limit = 1'b1;
         if (SATURATE) begin
            next_count = count;
         end else begin
            next_count = LIM[WIDTH-1:0];
            wrap_evt   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sync_updown_counter.sv
// Fully synchronous up/down counter with parallel load, modulo limit, wrap/saturate
// mode and a combinational terminal count for cascading.
module sync_updown_counter #(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned MODULO   = 16,
   parameter bit          SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap,
   output logic             sat
);
   import sync_updown_counter_pkg::*;

   localparam logic [WIDTH:0] LIM = (WIDTH+1)'(MODULO - 1);

   logic [WIDTH-1:0] nxt;
   logic [WIDTH-1:0] load_clamped;
   logic             at_limit;
   logic             wrap_evt;
   state_t           state;

   counter_next_val #(
      .WIDTH    (WIDTH),
      .MODULO   (MODULO),
      .SATURATE (SATURATE)
   ) u_next (
      .count      (count),
      .up_dn      (up_dn),
      .next_count (nxt),
      .at_limit   (at_limit),
      .wrap_evt   (wrap_evt)
   );

   assign load_clamped = ({1'b0, load_val} > LIM) ? LIM[WIDTH-1:0] : load_val;

   // zero latency so the next stage can use this directly as its enable
   assign tc = en & ((up_dn == DIR_UP) ? ({1'b0, count} == LIM) : (count == '0));

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         wrap  <= 1'b0;
         sat   <= 1'b0;
         state <= ST_IDLE;
      end else if (load) begin
         count <= load_clamped;
         wrap  <= 1'b0;
         sat   <= 1'b0;
         state <= en ? ST_COUNT : ST_IDLE;
      end else if (en) begin
         count <= nxt;
         wrap  <= wrap_evt;
         if (SATURATE && at_limit) begin
            sat   <= 1'b1;
            state <= ST_SAT;
         end else begin
            sat   <= 1'b0;
            state <= ST_COUNT;
         end
      end else begin
         // idle: count and sat hold; a held limit stays flagged
         wrap  <= 1'b0;
         state <= (state == ST_SAT) ? ST_SAT : ST_IDLE;
      end
   end

endmodule

// File: tb/tb_sync_updown_counter.sv
// Directed-vector bench: wrap instance, saturate instance, and a two-stage cascade.
module tb_sync_updown_counter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst, en, up_dn, load;
      logic [3:0] load_val;
      logic [3:0] count;
      logic       tc, wrap, sat;
   } vec_t;

   // wrap-mode DUT (MODULO=10)
   logic       w_rst, w_en, w_up, w_load;
   logic [3:0] w_lv, w_count;
   logic       w_tc, w_wrap, w_sat;
   // saturate-mode DUT (MODULO=10)
   logic       s_rst, s_en, s_up, s_load;
   logic [3:0] s_lv, s_count;
   logic       s_tc, s_wrap, s_sat;
   // cascade pair (MODULO=16)
   logic       c_rst, c_en;
   logic [3:0] c0_count, c1_count;
   logic       c0_tc, c1_tc, c0_wrap, c1_wrap, c0_sat, c1_sat;

   int checks = 0;
   int errors = 0;

   sync_updown_counter #(.WIDTH(4), .MODULO(10), .SATURATE(1'b0)) dut_w (
      .clk(clk), .rst(w_rst), .en(w_en), .up_dn(w_up), .load(w_load), .load_val(w_lv),
      .count(w_count), .tc(w_tc), .wrap(w_wrap), .sat(w_sat));

   sync_updown_counter #(.WIDTH(4), .MODULO(10), .SATURATE(1'b1)) dut_s (
      .clk(clk), .rst(s_rst), .en(s_en), .up_dn(s_up), .load(s_load), .load_val(s_lv),
      .count(s_count), .tc(s_tc), .wrap(s_wrap), .sat(s_sat));

   sync_updown_counter #(.WIDTH(4), .MODULO(16), .SATURATE(1'b0)) dut_c0 (
      .clk(clk), .rst(c_rst), .en(c_en), .up_dn(1'b1), .load(1'b0), .load_val(4'd0),
      .count(c0_count), .tc(c0_tc), .wrap(c0_wrap), .sat(c0_sat));

   sync_updown_counter #(.WIDTH(4), .MODULO(16), .SATURATE(1'b0)) dut_c1 (
      .clk(clk), .rst(c_rst), .en(c0_tc), .up_dn(1'b1), .load(1'b0), .load_val(4'd0),
      .count(c1_count), .tc(c1_tc), .wrap(c1_wrap), .sat(c1_sat));

   task automatic chk(input string name, input int idx, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic rst, en, up, ld, input logic [3:0] lv,
                               input logic [3:0] cnt, input logic t, w, s);
      vec_t v;
      v.rst = rst; v.en = en; v.up_dn = up; v.load = ld; v.load_val = lv;
      v.count = cnt; v.tc = t; v.wrap = w; v.sat = s;
      return v;
   endfunction

   // apply one vector to the selected DUT, check just after the edge
   task automatic apply(input vec_t v, input bit use_sat, input int idx);
      @(negedge clk);
      if (use_sat) begin
         s_rst = v.rst; s_en = v.en; s_up = v.up_dn; s_load = v.load; s_lv = v.load_val;
      end else begin
         w_rst = v.rst; w_en = v.en; w_up = v.up_dn; w_load = v.load; w_lv = v.load_val;
      end
      @(posedge clk);
      #1;
      if (use_sat) begin
         chk("s_count", idx, s_count, v.count);
         chk("s_tc",    idx, s_tc,    v.tc);
         chk("s_wrap",  idx, s_wrap,  v.wrap);
         chk("s_sat",   idx, s_sat,   v.sat);
      end else begin
         chk("w_count", idx, w_count, v.count);
         chk("w_tc",    idx, w_tc,    v.tc);
         chk("w_wrap",  idx, w_wrap,  v.wrap);
         chk("w_sat",   idx, w_sat,   v.sat);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tw[$];
      vec_t ts[$];
      w_rst = 1; w_en = 0; w_up = 1; w_load = 0; w_lv = 0;
      s_rst = 1; s_en = 0; s_up = 1; s_load = 0; s_lv = 0;
      c_rst = 1; c_en = 0;

      //            rst en up ld lv   cnt tc wr sat
      tw.push_back(mk(1, 1, 1, 0, 0,   0, 0, 0, 0));
      tw.push_back(mk(1, 1, 1, 0, 0,   0, 0, 0, 0));
      for (int i = 1; i <= 9; i++)
         tw.push_back(mk(0, 1, 1, 0, 0, 4'(i), (i == 9), 0, 0));
      tw.push_back(mk(0, 1, 1, 0, 0,   0, 0, 1, 0));   // 9 -> 0 wraps
      tw.push_back(mk(0, 0, 1, 0, 0,   0, 0, 0, 0));   // hold, wrap clears
      tw.push_back(mk(0, 1, 1, 1, 13,  9, 1, 0, 0));   // load clamps over en
      tw.push_back(mk(0, 1, 1, 0, 0,   0, 0, 1, 0));
      tw.push_back(mk(0, 1, 0, 0, 0,   9, 0, 1, 0));   // down wrap 0 -> 9
      tw.push_back(mk(0, 1, 0, 0, 0,   8, 0, 0, 0));
      tw.push_back(mk(0, 0, 1, 1, 6,   6, 0, 0, 0));
      tw.push_back(mk(0, 1, 1, 0, 0,   7, 0, 0, 0));
      tw.push_back(mk(1, 1, 1, 0, 0,   0, 0, 0, 0));   // reset mid-count
      tw.push_back(mk(0, 1, 1, 0, 0,   1, 0, 0, 0));
      tw.push_back(mk(0, 1, 0, 0, 0,   0, 1, 0, 0));   // direction flip, no stall
      tw.push_back(mk(0, 1, 0, 0, 0,   9, 0, 1, 0));
      tw.push_back(mk(0, 0, 1, 1, 9,   9, 0, 0, 0));   // load exactly MODULO-1
      tw.push_back(mk(0, 0, 1, 1, 15,  9, 0, 0, 0));
      tw.push_back(mk(1, 1, 1, 1, 5,   0, 0, 0, 0));   // rst beats load

      ts.push_back(mk(1, 1, 1, 0, 0,   0, 0, 0, 0));
      ts.push_back(mk(1, 1, 1, 0, 0,   0, 0, 0, 0));
      ts.push_back(mk(0, 0, 1, 1, 2,   2, 0, 0, 0));
      ts.push_back(mk(0, 1, 0, 0, 0,   1, 0, 0, 0));
      ts.push_back(mk(0, 1, 0, 0, 0,   0, 1, 0, 0));
      ts.push_back(mk(0, 1, 0, 0, 0,   0, 1, 0, 1));   // first hold sets sat
      ts.push_back(mk(0, 1, 0, 0, 0,   0, 1, 0, 1));
      ts.push_back(mk(0, 0, 0, 0, 0,   0, 0, 0, 1));   // en=0 keeps sat
      ts.push_back(mk(0, 1, 1, 0, 0,   1, 0, 0, 0));   // opposite dir leaves SAT
      ts.push_back(mk(0, 0, 1, 1, 9,   9, 0, 0, 0));
      ts.push_back(mk(0, 1, 1, 0, 0,   9, 1, 0, 1));   // top limit holds, no wrap
      ts.push_back(mk(0, 1, 1, 0, 0,   9, 1, 0, 1));
      ts.push_back(mk(0, 1, 1, 1, 3,   3, 0, 0, 0));   // load clears sat
      ts.push_back(mk(0, 1, 0, 1, 0,   0, 1, 0, 0));
      ts.push_back(mk(0, 1, 0, 0, 0,   0, 1, 0, 1));
      ts.push_back(mk(1, 1, 0, 0, 0,   0, 1, 0, 0));   // rst clears sat

      foreach (tw[i]) apply(tw[i], 1'b0, i);
      foreach (ts[i]) apply(ts[i], 1'b1, i);

      // cascade: 8-bit combined value counts 0..255 and back to 0
      @(negedge clk); c_rst = 1; c_en = 1;
      @(posedge clk); #1;
      chk("c_reset", 0, {c1_count, c0_count}, 0);
      @(negedge clk); c_rst = 0;
      for (int i = 1; i <= 256; i++) begin
         @(posedge clk); #1;
         chk("c_value", i, {c1_count, c0_count}, i % 256);
      end
      chk("c1_wrap", 256, c1_wrap, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
